uart_tx_fifo: RTL and testbench

- Byte buffer and launch controller directly upstream of uart_top's transmit side.
- Accepts bytes from a host write port into a circular FIFO.
- Drives uart_top's dintx/newd one byte at a time and pops each byte when uart_top's donetx rises.
- Lets the host queue bursts without polling transmitter status; runs in the same clk domain as uart_top.

---
 rtl/uart_tx_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch controller feeding uart_top's transmitter
//
// Ports:
//   clk       in   system clock, shared with uart_top
//   rst       in   synchronous active-high reset; clears FIFO and controller
//   wr_en     in   host write strobe
//   wr_data   in   [7:0] byte to enqueue when wr_en=1
//   full      out  count == DEPTH (registered)
//   empty     out  count == 0 (registered)
//   count     out  [ADDR_W:0] bytes stored, including the one being sent
//   overflow  out  one-cycle pulse after a write was dropped
//   dintx     out  [7:0] head byte presented to uart_top
//   newd      out  launch request to uart_top
//   donetx    in   uart_top transmit-complete level
//   busy      out  controller is in SEND or RELEASE

module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        dintx,
  output logic              newd,
  input  logic              donetx,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO   = '0;
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  state_t            state_next;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;

  logic              donetx_q;
  logic              done_rise;
  logic              wr_accept;
  logic              pop;
  logic              load_head;

  // Only a fresh edge of donetx counts as completion; uart_top may hold the
  // level for several cycles.
  assign done_rise = donetx & ~donetx_q;

  // Registered full gates the write, so a write while full is dropped even
  // if the head is popped on the same edge.
  assign wr_accept = wr_en & ~full;

  // ------------------------------------------------------------------
  // Controller: next state and outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    newd       = 1'b0;
    busy       = 1'b0;
    pop        = 1'b0;
    load_head  = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = SEND;
          load_head  = 1'b1;
        end
      end

      SEND: begin
        newd = 1'b1;
        busy = 1'b1;
        if (done_rise) begin
          pop        = 1'b1;
          state_next = RELEASE;
        end
      end

      // Hold newd low until uart_top drops donetx, otherwise it would see
      // newd still high and re-launch the byte just finished.
      RELEASE: begin
        busy = 1'b1;
        if (!donetx) begin
          if (count != CNT_ZERO) begin
            state_next = SEND;
            load_head  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Occupancy
  // ------------------------------------------------------------------
  always_comb begin
    count_next = count;
    case ({wr_accept, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // ------------------------------------------------------------------
  // State, pointers, flags
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      donetx_q <= 1'b0;
      dintx    <= 8'h00;
    end else begin
      state    <= state_next;
      donetx_q <= donetx;
      overflow <= wr_en & full;
      count    <= count_next;
      full     <= (count_next == FULL_COUNT);
      empty    <= (count_next == CNT_ZERO);

      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      // Head is captured once on entry to SEND so dintx stays stable for
      // the whole frame regardless of writes landing behind it. On the
      // RELEASE->SEND path rd_ptr has already moved past the popped byte.
      if (load_head) begin
        dintx <= mem[rd_ptr];
      end
    end
  end

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural transmitter

module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk     = 1'b0;
  logic              rst     = 1'b1;
  logic              wr_en   = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              donetx  = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [7:0]        dintx;
  logic              newd;
  logic              busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .dintx    (dintx),
    .newd     (newd),
    .donetx   (donetx),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: occupancy and the ordered list of accepted bytes.
  int         ref_cnt = 0;
  bit         exp_ovf = 0;
  bit         dq_ref  = 0;
  logic [7:0] hist[$];

  // Transmitter model state.
  int         launch_idx  = 0;
  bit         tx_busy     = 0;
  bit         tx_launched = 0;
  int         wait_cnt    = 0;
  int         done_cnt    = 0;
  logic [7:0] cap_byte    = 8'h00;
  int         spur_done_n = 0;

  // Knobs driven by the main stimulus.
  bit hold     = 0;
  int wait_min = 0;
  int wait_max = 3;
  int hold_min = 1;
  int hold_max = 2;
  int spur_req_n = 0;

  // Reference model: queue occupancy from the write/pop rules.
  initial begin
    bit rise;
    forever begin
      @(posedge clk);
      if (rst) begin
        ref_cnt = 0;
        exp_ovf = 0;
        dq_ref  = 0;
      end else begin
        rise    = donetx && !dq_ref;
        dq_ref  = donetx;
        exp_ovf = wr_en && (ref_cnt == DEPTH);
        if (wr_en && ref_cnt < DEPTH) begin
          ref_cnt++;
          hist.push_back(wr_data);
        end
        if (rise && tx_launched) ref_cnt--;
      end
    end
  end

  // Behavioural uart_top transmit side: accepts newd, checks the byte
  // against the accepted order, reports completion after a random delay.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        donetx      = 1'b0;
        tx_busy     = 0;
        tx_launched = 0;
        done_cnt    = 0;
        launch_idx  = hist.size();
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          donetx      = 1'b0;
          tx_launched = 0;
        end
      end else if (tx_busy) begin
        chk("dintx_stable", int'(dintx), int'(cap_byte));
        if (wait_cnt == 0) begin
          donetx   = 1'b1;
          done_cnt = int'($urandom_range(hold_max, hold_min));
          tx_busy  = 0;
        end else begin
          wait_cnt--;
        end
      end else if (newd && !hold) begin
        chk("launch_in_range", int'(launch_idx < hist.size()), 1);
        if (launch_idx < hist.size())
          chk("launch_byte", int'(dintx), int'(hist[launch_idx]));
        cap_byte    = dintx;
        launch_idx++;
        tx_launched = 1;
        tx_busy     = 1;
        wait_cnt    = int'($urandom_range(wait_max, wait_min));
      end else if (spur_done_n < spur_req_n && !newd) begin
        donetx   = 1'b1;
        done_cnt = 1;
        spur_done_n++;
      end
    end
  end

  // Monitor: occupancy flags every cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("count",    int'(count),    ref_cnt);
      chk("full",     int'(full),     int'(ref_cnt == DEPTH));
      chk("empty",    int'(empty),    int'(ref_cnt == 0));
      chk("overflow", int'(overflow), int'(exp_ovf));
    end
  end

  task automatic drain();
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (empty && !busy && !donetx) break;
    end
    chk("drain_done", int'(t < 3000), 1);
  endtask

  task automatic write_burst(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'(first + i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    bit found;

    // Reset
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    chk("rst_newd",  int'(newd),  0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_dintx", int'(dintx), 0);
    rst = 1'b0;

    // Single byte and write-to-newd latency
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h0A;
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat1_newd",  int'(newd),  0);
    chk("lat1_empty", int'(empty), 0);
    @(negedge clk);
    chk("lat2_newd",  int'(newd),  1);
    chk("lat2_busy",  int'(busy),  1);
    chk("lat2_dintx", int'(dintx), 8'h0A);
    drain();
    chk("single_busy", int'(busy), 0);
    chk("single_sent", launch_idx, hist.size());

    // Burst 10..19
    write_burst(10, 10);
    drain();
    chk("burst_sent", launch_idx, hist.size());

    // Overflow with transmitter stalled
    hold = 1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) chk("ovf_full16", int'(full), 1);
      wr_en   = 1'b1;
      wr_data = 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    @(negedge clk);
    chk("ovf_once", int'(overflow), 0);
    hold = 0;
    drain();
    chk("ovf_sent", launch_idx, hist.size());
    chk("ovf_last", int'(cap_byte), 8'h0F);

    // Write and pop on the same edge with count=3
    hold = 1;
    write_burst(8'h30, 3);
    repeat (3) @(negedge clk);
    chk("sim_pre", int'(count), 3);
    wait_min = 1; wait_max = 1; hold_min = 1; hold_max = 1;
    hold = 0;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (donetx) found = 1;
    end
    chk("sim_rise_seen", int'(found), 1);
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("sim_count", int'(count), 3);
    wait_min = 0; wait_max = 3; hold_min = 1; hold_max = 2;
    drain();
    chk("sim_sent", launch_idx, hist.size());
    chk("sim_last", int'(cap_byte), 8'hA5);

    // donetx rising while idle must not pop
    spur_req_n++;
    repeat (4) @(negedge clk);
    chk("spur_issued", spur_done_n, spur_req_n);
    chk("spur_newd", int'(newd), 0);
    chk("spur_busy", int'(busy), 0);

    // Reset mid-frame
    hold = 1;
    write_burst(8'h60, 5);
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (newd) found = 1;
    end
    chk("rstm_send", int'(found), 1);
    chk("rstm_count", int'(count), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_newd",  int'(newd),  0);
    chk("rstm_count0", int'(count), 0);
    chk("rstm_empty", int'(empty), 1);
    chk("rstm_busy",  int'(busy),  0);
    hold = 0;
    write_burst(8'h55, 1);
    drain();
    chk("rstm_sent", launch_idx, hist.size());
    chk("rstm_byte", int'(cap_byte), 8'h55);

    // Randomized traffic
    wait_max = 6;
    hold_max = 3;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(2, 0) == 0);
      wr_data = 8'($urandom);
    end
    @(negedge clk);
    wr_en = 1'b0;
    drain();
    chk("rand_sent", launch_idx, hist.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
